// File: rtl/key_sel_toggle.sv
// Push-button debouncer: each confirmed press gives a one-cycle flag and toggles a mux select.
// It also exports the debounced key level.
module key_sel_toggle #(
  parameter int unsigned CNT_MAX    = 999_999,
  parameter logic        KEY_ACTIVE = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_flag,
  output logic key_level,
  output logic sel
);

  localparam int unsigned CntW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CNT_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StPressFilter,
    StPressed,
    StReleaseFilter
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            key_s1_q, key_s2_q;
  logic            key_flag_q, key_flag_d;
  logic            key_level_q, key_level_d;
  logic            sel_q, sel_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      key_s1_q    <= 1'b0;
      key_s2_q    <= 1'b0;
      key_flag_q  <= 1'b0;
      key_level_q <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      // Normalised so that 1 always means pressed.
      key_s1_q    <= (key_in == KEY_ACTIVE);
      key_s2_q    <= key_s1_q;
      key_flag_q  <= key_flag_d;
      key_level_q <= key_level_d;
      sel_q       <= sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_flag_d  = 1'b0;
    key_level_d = key_level_q;
    sel_d       = sel_q;
    unique case (state_q)
      StIdle: begin
        if (key_s2_q) begin
          state_d = StPressFilter;
          cnt_d   = '0;
        end
      end
      StPressFilter: begin
        if (!key_s2_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d     = StPressed;
          key_flag_d  = 1'b1;
          key_level_d = 1'b1;
          sel_d       = ~sel_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (!key_s2_q) begin
          state_d = StReleaseFilter;
          cnt_d   = '0;
        end
      end
      StReleaseFilter: begin
        // A bounce back to pressed resumes the held state without a new flag.
        if (key_s2_q) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d     = StIdle;
          key_level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign key_flag  = key_flag_q;
  assign key_level = key_level_q;
  assign sel       = sel_q;

endmodule
